// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Drives all eight input rows of a 3-input combinational gate network in
// ascending order {in1,in2,in3}. Each row is held for SETTLE_CYCLES cycles
// and then sampled in a single SAMPLE cycle. The samples are shifted into an
// 8-bit signature so that row 0 lands in bit 7. At the end of the sweep the
// signature is compared with EXPECTED.
//
// Optional feature macro: TT_SWEEP_STABILITY_EN
//   defined   : dut_out is also captured on the last SETTLE cycle of each row.
//               Any difference from the SAMPLE value sets unstable, which
//               stays set until the next start and forces pass low.
//   undefined : one sample per row; unstable is tied low.
//
// Handshake: start is a level that is sampled only in IDLE, and only when
// abort is low at the same edge. There is no ready/acknowledge signal:
// busy=1 means any start is ignored. done is a one-cycle pulse, and
// signature/pass stay valid after it until the next accepted start.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'h1E
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       dut_in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] signature,
  output logic       pass,
  output logic       unstable,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] row;
  logic [7:0] cnt;
  logic [7:0] sig_nxt;
  logic       last_settle;
  logic       unstable_nxt;

  // The signature value as it will be after this row's SAMPLE shift. It is
  // used so that pass can be decided on the same edge that captures row 7.
  assign sig_nxt     = {signature[6:0], dut_out};
  assign last_settle = (state == SETTLE) && (cnt == 8'(SETTLE_CYCLES - 1));
  assign state_dbg   = state;

`ifdef TT_SWEEP_STABILITY_EN
  logic settle_val;
  logic unstable_q;

  assign unstable_nxt = unstable_q | ((state == SAMPLE) && (dut_out != settle_val));
  assign unstable     = unstable_q;

  // Capture the late-settle value and accumulate instability across a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_val <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      if (last_settle) settle_val <= dut_out;
      if (state == IDLE && start && !abort) unstable_q <= 1'b0;
      else if (state == SAMPLE)             unstable_q <= unstable_nxt;
    end
  end
`else
  assign unstable_nxt = 1'b0;
  assign unstable     = 1'b0;
`endif

  // Sweep sequencer: the row/settle counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= 3'd0;
      cnt       <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= 8'h00;
      dut_in1   <= 1'b0;
      dut_in2   <= 1'b0;
      dut_in3   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state     <= SETTLE;
            row       <= 3'd0;
            cnt       <= 8'd0;
            signature <= 8'h00;
            pass      <= 1'b0;
            busy      <= 1'b1;
            {dut_in1, dut_in2, dut_in3} <= 3'd0;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
            cnt   <= 8'd0;
            {dut_in1, dut_in2, dut_in3} <= 3'd0;
          end else if (last_settle) begin
            state <= SAMPLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            // The partial signature is kept for debug; only the drives clear.
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
            cnt   <= 8'd0;
            {dut_in1, dut_in2, dut_in3} <= 3'd0;
          end else begin
            signature <= sig_nxt;
            if (row != 3'd7) begin
              row   <= row + 3'd1;
              state <= SETTLE;
              {dut_in1, dut_in2, dut_in3} <= row + 3'd1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (sig_nxt == EXPECTED) && !unstable_nxt;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper. It models the gate network as
// out = in1 ^ (in2 & in3), a constant 1, or a version that glitches on row 2.
// Expected done events ({signature, pass, unstable}) are queued by the driver.
// A negedge monitor pops one entry on every done pulse and checks it,
// including the latency from start.
module tb_truth_table_sweeper;

  localparam int S   = 4;
  localparam int LAT = 8 * (S + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       dut_out;
  logic       dut_in1, dut_in2, dut_in3;
  logic       busy, done, pass, unstable;
  logic [7:0] signature;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  int tick     = 0;
  int t0       = 0;
  int mode     = 0;
  bit glitch_en = 1'b0;

  logic [9:0] exp_q[$];

  truth_table_sweeper #(.SETTLE_CYCLES(S), .EXPECTED(8'h1E)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
    .dut_in1(dut_in1), .dut_in2(dut_in2), .dut_in3(dut_in3),
    .busy(busy), .done(done), .signature(signature), .pass(pass),
    .unstable(unstable), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  // network model; the glitch variant flips the output on the last SETTLE cycle of row 2
  assign dut_out = (mode == 1) ? 1'b1 :
                   ((dut_in1 ^ (dut_in2 & dut_in3)) ^ (glitch_en && ((tick - t0) == 13)));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    t0    = tick;
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] sig, input logic p, input logic u);
    exp_q.push_back({sig, p, u});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (done) break;
      @(posedge clk);
      #1;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_unstable"}, {31'd0, unstable}, 32'd0);
    chk({tag, "_signature"}, {24'd0, signature}, 32'h00);
    chk({tag, "_dut_in"}, {29'd0, dut_in1, dut_in2, dut_in3}, 32'd0);
    chk({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_signature", {24'd0, signature}, {24'd0, e[9:2]});
        chk("sb_pass", {31'd0, pass}, {31'd0, e[1]});
        chk("sb_unstable", {31'd0, unstable}, {31'd0, e[0]});
        chk("sb_latency", tick - t0, LAT);
      end
    end
  end

  initial begin
    // reset block
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    step(3);
    chk_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // 1: 0x1E network; row order check
    mode = 0;
    push_exp(8'h1E, 1'b1, 1'b0);
    issue_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int c = 0; c < LAT; c++) begin
      if (c % (S + 1) == 0)
        chk("row_drive", {29'd0, dut_in1, dut_in2, dut_in3}, c / (S + 1));
      step(1);
    end
    wait_done();
    chk("done_busy_high", {31'd0, busy}, 32'd1);
    step(1);
    chk("busy_falls", {31'd0, busy}, 32'd0);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("pass_held", {31'd0, pass}, 32'd1);
    chk("sig_held", {24'd0, signature}, 32'h1E);

    // 2: constant-1 network
    mode = 1;
    push_exp(8'hFF, 1'b0, 1'b0);
    issue_start();
    wait_done();
    step(1);
    mode = 0;

    // 3: start re-pulsed at row 3 is ignored; then a back-to-back start
    push_exp(8'h1E, 1'b1, 1'b0);
    issue_start();
    step(16);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done();
    step(1);
    chk("b2b_idle_gap", {31'd0, busy}, 32'd0);
    push_exp(8'h1E, 1'b1, 1'b0);
    issue_start();
    chk("b2b_accepted", {31'd0, busy}, 32'd1);
    wait_done();
    step(1);

    // 4: abort during row 5 SETTLE
    issue_start();
    step(26);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_dut_in", {29'd0, dut_in1, dut_in2, dut_in3}, 32'd0);
    chk("abort_pass", {31'd0, pass}, 32'd0);
    chk("abort_partial_sig", {24'd0, signature}, 32'h03);
    chk("abort_state", {30'd0, state_dbg}, 32'd0);
    step(50);
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);
    // start masked by simultaneous abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    chk("start_masked", {31'd0, busy}, 32'd0);
    step(3);
    chk("start_masked_later", {31'd0, busy}, 32'd0);

    // 5: asynchronous reset at row 6
    issue_start();
    step(31);
    chk("pre_reset_sig", {24'd0, signature}, 32'h07);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    push_exp(8'h1E, 1'b1, 1'b0);
    issue_start();
    wait_done();
    step(1);

    // 6: row-2 glitch between the last SETTLE cycle and SAMPLE
    glitch_en = 1'b1;
`ifdef TT_SWEEP_STABILITY_EN
    push_exp(8'h1E, 1'b0, 1'b1);
`else
    push_exp(8'h1E, 1'b1, 1'b0);
`endif
    issue_start();
    wait_done();
    step(1);
    glitch_en = 1'b0;
    // unstable clears on the next start
    push_exp(8'h1E, 1'b1, 1'b0);
    issue_start();
    chk("unstable_cleared", {31'd0, unstable}, 32'd0);
    wait_done();
    step(2);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
